// File: rtl/wb_arbiter_pkg.sv
// Shared Wishbone types for the arbiter slice: request/response layouts,
// flattened widths, arbiter state encoding and a one-hot decode helper.
package wb_arbiter_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
  } wb_m2s_t;

  typedef struct packed {
    logic [31:0] data;
    logic        ack;
  } wb_s2m_t;

  localparam int unsigned WB_M2S_W = $bits(wb_m2s_t);
  localparam int unsigned WB_S2M_W = $bits(wb_s2m_t);

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the shared slave.
// slave modport = arbiter view; master modport = requesters plus shared slave.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2
);
  logic [NUM_MASTERS*WB_M2S_W-1:0] i_m2s_wb;
  logic [NUM_MASTERS*WB_S2M_W-1:0] o_s2m_wb;
  logic [WB_M2S_W-1:0]             o_m2s_wb;
  logic [WB_S2M_W-1:0]             i_s2m_wb;

  modport slave (
    input  i_m2s_wb,
    input  i_s2m_wb,
    output o_s2m_wb,
    output o_m2s_wb
  );

  modport master (
    output i_m2s_wb,
    output i_s2m_wb,
    input  o_s2m_wb,
    input  o_m2s_wb
  );
endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin selector: first request at or after the pointer,
// wrapping; one-hot grant plus valid.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_valid
);
  logic [2*NUM_REQ-1:0] req2;
  logic [2*NUM_REQ-1:0] gnt2;
  logic [NUM_REQ-1:0]   rot_req;
  logic [NUM_REQ-1:0]   rot_gnt;

  // Rotate requests so the pointer lands on bit 0, fixed-priority pick, rotate back.
  always_comb begin
    req2    = {i_req, i_req} >> i_ptr;
    rot_req = req2[NUM_REQ-1:0];
    rot_gnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rot_req[i] && (rot_gnt == '0)) rot_gnt[i] = 1'b1;
    end
    gnt2    = {{NUM_REQ{1'b0}}, rot_gnt} << i_ptr;
    o_gnt   = gnt2[NUM_REQ-1:0] | gnt2[2*NUM_REQ-1:NUM_REQ];
    o_valid = |i_req;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave among NUM_MASTERS masters.
// Optional watchdog forced-ack and sticky o_timeout under `WB_ARB_TIMEOUT_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  wb_arbiter_if.slave            bus,
  output logic [NUM_MASTERS-1:0] o_grant,
  output logic                   o_busy
`ifdef WB_ARB_TIMEOUT_EN
  ,
  output logic                   o_timeout
`endif
);
  localparam int unsigned IDX_W = (NUM_MASTERS > 2) ? 2 : 1;

  arb_state_t             state;
  logic [IDX_W-1:0]       gidx;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       next_ptr;
  logic [IDX_W-1:0]       pick_ptr;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_valid;
  wb_m2s_t                granted;
  wb_m2s_t                req_slice;
  wb_m2s_t                to_slave;
  logic                   force_ack;

  always_comb begin
    req       = '0;
    req_slice = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      req_slice = wb_m2s_t'(bus.i_m2s_wb[k*WB_M2S_W +: WB_M2S_W]);
      req[k]    = req_slice.cyc;
    end
  end

  assign granted  = wb_m2s_t'(bus.i_m2s_wb[32'(gidx)*WB_M2S_W +: WB_M2S_W]);
  assign next_ptr = (gidx == IDX_W'(NUM_MASTERS - 1)) ? '0 : gidx + 1'b1;
  // On release the hand-off search already uses the advanced pointer.
  assign pick_ptr = (state == ARB_OWNED) ? next_ptr : ptr;
  assign pick_idx = IDX_W'(onehot_to_idx(4'(pick_gnt)));

  rr_pick #(
    .NUM_REQ (NUM_MASTERS),
    .PTR_W   (IDX_W)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (pick_ptr),
    .o_gnt   (pick_gnt),
    .o_valid (pick_valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ARB_IDLE;
      o_grant <= '0;
      o_busy  <= 1'b0;
      gidx    <= '0;
      ptr     <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state   <= ARB_OWNED;
            o_grant <= pick_gnt;
            o_busy  <= 1'b1;
            gidx    <= pick_idx;
          end
        end
        ARB_OWNED: begin
          if (!granted.cyc) begin
            ptr <= next_ptr;
            if (pick_valid) begin
              o_grant <= pick_gnt;
              gidx    <= pick_idx;
            end else begin
              state   <= ARB_IDLE;
              o_grant <= '0;
              o_busy  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  wb_s2m_t         slv_rsp;
  logic [TO_W-1:0] to_cnt;

  assign slv_rsp   = wb_s2m_t'(bus.i_s2m_wb);
  assign force_ack = (state == ARB_OWNED) && granted.stb && (to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      to_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (force_ack) o_timeout <= 1'b1;
      if ((state != ARB_OWNED) || !granted.cyc || slv_rsp.ack || force_ack) begin
        to_cnt <= '0;
      end else if (granted.stb) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
`else
  assign force_ack = 1'b0;
`endif

  always_comb begin
    bus.o_m2s_wb = '0;
    bus.o_s2m_wb = '0;
    to_slave     = granted;
    if (force_ack) to_slave.stb = 1'b0;
    if (state == ARB_OWNED) begin
      bus.o_m2s_wb = to_slave;
      bus.o_s2m_wb[32'(gidx)*WB_S2M_W +: WB_S2M_W] =
        force_ack ? wb_s2m_t'{data: '0, ack: 1'b1} : bus.i_s2m_wb;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a
// queue-free ownership model; timeout scenario under `WB_ARB_TIMEOUT_EN.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] grant;
  logic         busy;
`ifdef WB_ARB_TIMEOUT_EN
  logic         timeout;
`endif

  wb_arbiter_if #(.NUM_MASTERS(N)) bus ();

  wb_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus),
    .o_grant   (grant),
    .o_busy    (busy)
`ifdef WB_ARB_TIMEOUT_EN
    ,
    .o_timeout (timeout)
`endif
  );

  always #5 clk = ~clk;

  logic        m_cyc  [N];
  logic        m_stb  [N];
  logic        m_we   [N];
  logic [31:0] m_addr [N];
  logic [31:0] m_data [N];
  logic [3:0]  m_sel  [N];
  logic        slv_ready;
  wb_m2s_t     sreq;

  always_comb begin
    bus.i_m2s_wb = '0;
    for (int k = 0; k < N; k++)
      bus.i_m2s_wb[k*WB_M2S_W +: WB_M2S_W] = {m_addr[k], m_data[k], m_sel[k], m_we[k], m_stb[k], m_cyc[k]};
  end

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Shared slave: combinational ack whenever ready.
  always_comb begin
    sreq         = wb_m2s_t'(bus.o_m2s_wb);
    bus.i_s2m_wb = (sreq.cyc && sreq.stb && slv_ready) ? {rdata_of(sreq.addr), 1'b1} : '0;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_ack(input int k);
    return bus.o_s2m_wb[k*WB_S2M_W];
  endfunction

  function automatic logic [31:0] get_rdata(input int k);
    return bus.o_s2m_wb[k*WB_S2M_W+1 +: 32];
  endfunction

  // Reference model: owner index (-1 idle), rotating pointer, watchdog count.
  int owner     = -1;
  int rr_ptr    = 0;
  int tocnt     = 0;
  bit to_sticky = 1'b0;

  function automatic int first_req(input int p);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (p + i) % N;
      if (m_cyc[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit forced_now();
`ifdef WB_ARB_TIMEOUT_EN
    return (owner >= 0) && m_stb[owner] && (tocnt == TO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit ack_now();
    return (owner >= 0) && m_cyc[owner] && m_stb[owner] && slv_ready && !forced_now();
  endfunction

  always @(posedge clk) begin : model
    bit f, a;
    f = forced_now();
    a = ack_now();
    if (rst) begin
      owner = -1; rr_ptr = 0; tocnt = 0; to_sticky = 1'b0;
    end else begin
      if (f) to_sticky = 1'b1;
      if (owner < 0 || !m_cyc[owner] || a || f) tocnt = 0;
      else if (m_stb[owner]) tocnt++;
      if (owner < 0) begin
        owner = first_req(rr_ptr);
      end else if (!m_cyc[owner]) begin
        rr_ptr = (owner + 1) % N;
        owner  = first_req(rr_ptr);
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin : compare
    logic [N-1:0]          eg;
    wb_m2s_t               em;
    logic [N*WB_S2M_W-1:0] es;
    bit                    f;
    if (cmp_en) begin
      eg = '0; em = '0; es = '0;
      f  = forced_now();
      if (owner >= 0) begin
        eg[owner] = 1'b1;
        em = {m_addr[owner], m_data[owner], m_sel[owner], m_we[owner], m_stb[owner], m_cyc[owner]};
        if (f) em.stb = 1'b0;
        if (f)              es[owner*WB_S2M_W +: WB_S2M_W] = {32'h0, 1'b1};
        else if (ack_now()) es[owner*WB_S2M_W +: WB_S2M_W] = {rdata_of(m_addr[owner]), 1'b1};
      end
      check("cmp_grant", grant, eg);
      check("cmp_busy", busy, owner >= 0);
      check("cmp_slave_req", bus.o_m2s_wb, em);
      check("cmp_master_rsp", bus.o_s2m_wb, es);
`ifdef WB_ARB_TIMEOUT_EN
      check("cmp_timeout", timeout, to_sticky);
`endif
    end
  end

  int           gseq[$];
  bit           obs_en = 1'b0;
  logic [N-1:0] prev_g = '0;

  always @(negedge clk) begin
    if (obs_en) begin
      if (grant != prev_g && grant != '0) gseq.push_back(int'(onehot_to_idx(4'(grant))));
      prev_g = grant;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drop(input int k);
    m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_we[k] = 1'b0;
  endtask

  task automatic beat(input int k, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m_cyc[k] = 1'b1; m_stb[k] = 1'b1; m_we[k] = we;
    m_addr[k] = a; m_data[k] = d; m_sel[k] = s;
  endtask

  // Returns at posedge+1 of the edge that completed the beat.
  task automatic wait_ack(input int k);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = get_ack(k);
      tick();
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_wait_m%0d: got no ack expected ack within 100 cycles", k);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic fair_master(input int k);
    repeat (5) begin
      beat(k, 1'b0, 32'(k * 16), 32'h0, 4'hF);
      wait_ack(k);
      drop(k);
      tick();
    end
  endtask

  task automatic rand_master(input int k);
    repeat (15) begin
      repeat ($urandom_range(1, 4)) tick();
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
        beat(k, 1'($urandom), $urandom, $urandom, 4'($urandom));
        wait_ack(k);
      end
      drop(k);
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    bit rdone;
    rst = 1'b1;
    slv_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      drop(k); m_addr[k] = '0; m_data[k] = '0; m_sel[k] = '0;
    end

    // Reset then idle
    @(posedge clk); cmp_en = 1'b1;
    tick();
    @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_slave_cyc", sreq.cyc, 1'b0);
    check("rst_acks", bus.o_s2m_wb, '0);
    tick();
    rst = 1'b0;

    // Single master write from master 1
    slv_ready = 1'b1;
    beat(1, 1'b1, 32'h4, 32'h0000_00A5, 4'b1111);
    @(negedge clk);
    check("single_arb_cycle_cyc", sreq.cyc, 1'b0);
    @(negedge clk);
    check("single_grant", grant, 2'b10);
    check("single_slave_addr", sreq.addr, 32'h4);
    check("single_slave_data", sreq.data, 32'hA5);
    check("single_slave_we", sreq.we, 1'b1);
    check("single_slave_sel", sreq.sel, 4'hF);
    check("single_m1_ack", get_ack(1), 1'b1);
    check("single_m0_ack", get_ack(0), 1'b0);
    tick();
    drop(1);
    @(negedge clk);
    @(negedge clk);
    check("single_release_grant", grant, 2'b00);

    // Contention after reset: master 0 first, then immediate hand-off
    tick();
    do_reset();
    beat(0, 1'b0, 32'h10, 32'h0, 4'hF);
    beat(1, 1'b0, 32'h20, 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check("cont_first_grant", grant, 2'b01);
    check("cont_m0_ack", get_ack(0), 1'b1);
    tick();
    drop(0);
    @(negedge clk);
    check("cont_m1_waits", get_ack(1), 1'b0);
    @(negedge clk);
    check("cont_handoff_grant", grant, 2'b10);
    check("cont_handoff_busy", busy, 1'b1);
    tick();
    drop(1);
    tick(); tick();

    // Fairness: both request continuously
    do_reset();
    obs_en = 1'b1;
    fork
      fair_master(0);
      fair_master(1);
    join
    tick(); tick();
    obs_en = 1'b0;
    check("fair_grant_count", gseq.size(), 10);
    for (int i = 0; i < gseq.size() && i < 10; i++) check("fair_order", gseq[i], i % 2);

    // Lock across beats, then reset mid-beat
    do_reset();
    beat(1, 1'b1, 32'h100, 32'h1, 4'hF);
    tick();
    beat(0, 1'b0, 32'h200, 32'h0, 4'hF);
    wait_ack(1);
    beat(1, 1'b1, 32'h104, 32'h2, 4'hF);
    wait_ack(1);
    beat(1, 1'b1, 32'h108, 32'h3, 4'hF);
    slv_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("lock_grant", grant, 2'b10);
      check("lock_m0_ack", get_ack(0), 1'b0);
      tick();
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("lock_rst_grant", grant, 2'b00);
    check("lock_rst_slave_cyc", sreq.cyc, 1'b0);
    check("lock_rst_m0_ack", get_ack(0), 1'b0);
    tick();
    rst = 1'b0;
    drop(0); drop(1);
    slv_ready = 1'b1;
    @(negedge clk);
    check("lock_after_grant", grant, 2'b00);
    tick();

    // Random traffic against the model
    do_reset();
    rdone = 1'b0;
    fork
      begin
        fork
          rand_master(0);
          rand_master(1);
        join
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          tick();
          slv_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    slv_ready = 1'b1;
    tick(); tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Hung slave: forced ack after TO waiting cycles, sticky flag
    begin
      int waited;
      bit got;
      do_reset();
      slv_ready = 1'b0;
      beat(0, 1'b0, 32'h300, 32'h0, 4'hF);
      @(negedge clk);
      waited = 0;
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge clk);
        if (get_ack(0)) got = 1'b1;
        else waited++;
      end
      check("to_forced_ack_seen", got, 1'b1);
      check("to_wait_cycles", waited, TO);
      check("to_forced_data", get_rdata(0), 32'h0);
      check("to_slave_stb", sreq.stb, 1'b0);
      tick();
      drop(0);
      repeat (3) begin
        @(negedge clk);
        check("to_sticky", timeout, 1'b1);
      end
      tick();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("to_cleared_by_reset", timeout, 1'b0);
      tick();
      rst = 1'b0;
      slv_ready = 1'b1;
      tick();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
